// File: rtl/io_arb_2to1_pkg.sv
// Shared globals for the 2-to-1 channel arbiter: field widths, on/off levels,
// FSM state type and the round-robin grant helper.
`ifndef NS_HGLOBAL_DEFS
`define NS_HGLOBAL_DEFS
`define NS_ADDRESS_SIZE 4
`define NS_DATA_SIZE 8
`define NS_REDUN_SIZE 4
`define NS_ON 1'b1
`define NS_OFF 1'b0
`endif

package io_arb_2to1_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACK_IN = 2'd1,
      SEND   = 2'd2,
      REL    = 2'd3
   } arbState_t;

   localparam logic GNT_I0       = 1'b0;
   localparam logic GNT_I1       = 1'b1;
   // Reset value of the last grant, so that input 0 wins the first tie after reset.
   localparam logic GNT_RESET    = GNT_I1;

   function automatic logic pickGrant(input logic req0, input logic req1, input logic lastGnt);
      if (req0 && req1) begin
         return ~lastGnt;
      end
      return req1 ? GNT_I1 : GNT_I0;
   endfunction

endpackage

// File: rtl/io_arb_2to1_calc_redun.sv
// Redundancy generator: XOR-folds the concatenated {src, dst, dat} fields into an RSZ-bit code.
module calc_redun #(
   parameter int ASZ = 4,
   parameter int DSZ = 8,
   parameter int RSZ = 4
)(
   input  logic [ASZ-1:0] src_i,
   input  logic [ASZ-1:0] dst_i,
   input  logic [DSZ-1:0] dat_i,
   output logic [RSZ-1:0] red_o
);

   localparam int TOTW   = 2*ASZ + DSZ;
   localparam int CHUNKS = (TOTW + RSZ - 1) / RSZ;

   logic [CHUNKS*RSZ-1:0] padded;

   always_comb begin
      padded            = '0;
      padded[TOTW-1:0]  = {src_i, dst_i, dat_i};
      red_o             = '0;
      for (int k = 0; k < CHUNKS; k++) begin
         red_o = red_o ^ padded[k*RSZ +: RSZ];
      end
   end

endmodule

// File: rtl/io_arb_2to1.sv
// Round-robin arbiter merging two req/ack message channels onto one output channel.
// Optional NS_ARB_REDUN_CHK_EN: drop (but ack) messages whose redundancy field is wrong, raising sticky err.
module io_arb_2to1
   import io_arb_2to1_pkg::*;
#(
   parameter int ASZ = `NS_ADDRESS_SIZE,
   parameter int DSZ = `NS_DATA_SIZE,
   parameter int RSZ = `NS_REDUN_SIZE
)(
   input  logic           clk,
   input  logic           reset,
   input  logic [ASZ-1:0] i0_src,
   input  logic [ASZ-1:0] i0_dst,
   input  logic [DSZ-1:0] i0_dat,
   input  logic [RSZ-1:0] i0_red,
   input  logic           i0_req,
   output logic           i0_ack,
   input  logic [ASZ-1:0] i1_src,
   input  logic [ASZ-1:0] i1_dst,
   input  logic [DSZ-1:0] i1_dat,
   input  logic [RSZ-1:0] i1_red,
   input  logic           i1_req,
   output logic           i1_ack,
   output logic [ASZ-1:0] o0_src,
   output logic [ASZ-1:0] o0_dst,
   output logic [DSZ-1:0] o0_dat,
   output logic [RSZ-1:0] o0_red,
   output logic           o0_req,
   input  logic           o0_ack,
   output logic           err,
   output logic           gnt_last
);

   arbState_t        state_q, state_d;
   logic             gntLast_q, gntLast_d;
   logic             bad_q, bad_d;
   logic [ASZ-1:0]   src_q, src_d;
   logic [ASZ-1:0]   dst_q, dst_d;
   logic [DSZ-1:0]   dat_q, dat_d;
   logic [RSZ-1:0]   red_q, red_d;

   logic             anyReq;
   logic             grantSel;
   logic             grantedReq;
   logic             grantEdge;
   logic             redBad;
   logic [ASZ-1:0]   selSrc;
   logic [ASZ-1:0]   selDst;
   logic [DSZ-1:0]   selDat;
   logic [RSZ-1:0]   selRed;
   logic [RSZ-1:0]   calcRed;

   assign anyReq     = i0_req | i1_req;
   assign grantSel   = pickGrant(i0_req, i1_req, gntLast_q);
   assign grantedReq = gntLast_q ? i1_req : i0_req;
   assign grantEdge  = (state_q == IDLE) && anyReq;

   assign selSrc = grantSel ? i1_src : i0_src;
   assign selDst = grantSel ? i1_dst : i0_dst;
   assign selDat = grantSel ? i1_dat : i0_dat;
   assign selRed = grantSel ? i1_red : i0_red;

   calc_redun #(
      .ASZ (ASZ),
      .DSZ (DSZ),
      .RSZ (RSZ)
   ) u_calc_redun (
      .src_i (selSrc),
      .dst_i (selDst),
      .dat_i (selDat),
      .red_o (calcRed)
   );

`ifdef NS_ARB_REDUN_CHK_EN
   logic err_q, err_d;

   assign redBad = (calcRed != selRed);
   assign err_d  = err_q | (grantEdge & redBad);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= `NS_OFF;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unusedCalcRed;

   assign unusedCalcRed = ^calcRed;
   assign redBad        = `NS_OFF;
   assign err           = `NS_OFF;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         gntLast_q <= GNT_RESET;
         bad_q     <= 1'b0;
         src_q     <= '0;
         dst_q     <= '0;
         dat_q     <= '0;
         red_q     <= '0;
      end else begin
         state_q   <= state_d;
         gntLast_q <= gntLast_d;
         bad_q     <= bad_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         dat_q     <= dat_d;
         red_q     <= red_d;
      end
   end

   // The message register only loads on the grant edge, so o0 fields are frozen for the whole SEND phase.
   always_comb begin
      state_d   = state_q;
      gntLast_d = gntLast_q;
      bad_d     = bad_q;
      src_d     = src_q;
      dst_d     = dst_q;
      dat_d     = dat_q;
      red_d     = red_q;
      case (state_q)
         IDLE: begin
            if (anyReq) begin
               state_d   = ACK_IN;
               gntLast_d = grantSel;
               bad_d     = redBad;
               src_d     = selSrc;
               dst_d     = selDst;
               dat_d     = selDat;
               red_d     = selRed;
            end
         end
         ACK_IN: begin
            if (!grantedReq) begin
               state_d = bad_q ? IDLE : SEND;
            end
         end
         SEND: begin
            if (o0_ack) begin
               state_d = REL;
            end
         end
         REL: begin
            if (!o0_ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs are decoded purely from the current state and the latched grant.
   always_comb begin
      i0_ack = `NS_OFF;
      i1_ack = `NS_OFF;
      o0_req = `NS_OFF;
      case (state_q)
         ACK_IN: begin
            if (gntLast_q) begin
               i1_ack = `NS_ON;
            end else begin
               i0_ack = `NS_ON;
            end
         end
         SEND:    o0_req = `NS_ON;
         default: o0_req = `NS_OFF;
      endcase
   end

   assign o0_src   = src_q;
   assign o0_dst   = dst_q;
   assign o0_dat   = dat_q;
   assign o0_red   = red_q;
   assign gnt_last = gntLast_q;

endmodule
